cache_arbiter: RTL and testbench
================================

# cache_arbiter

Shares the single cacheline adaptor/physical-memory port between the instruction cache and the data cache of the pipelined processor. Each cache's 256-bit `pmem_*` miss/writeback interface lands on one side. The arbiter registers the winning request onto the memory side and routes the response back to the winner only. Simultaneous misses are arbitrated round-robin, and per-requester grant counters are provided for performance debug.

## Interface
- `s_line`, 256: cacheline width in bits.
- `s_cnt`, 32: width of each grant/conflict counter.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous reset, active-low (0 = reset).
- `i_pmem_address`  in  32  I-cache line address.
- `i_pmem_read`  in  1  I-cache line fill request.
- `i_pmem_rdata`  out  s_line  fill data to I-cache.
- `i_pmem_resp`  out  1  I-cache transaction complete.
- `d_pmem_address`  in  32  D-cache line address.
- `d_pmem_read`  in  1  D-cache line fill request.
- `d_pmem_write`  in  1  D-cache writeback request.
- `d_pmem_wdata`  in  s_line  writeback data.
- `d_pmem_rdata`  out  s_line  fill data to D-cache.
- `d_pmem_resp`  out  1  D-cache transaction complete.
- `pmem_address`  out  32  registered address to adaptor.
- `pmem_read`  out  1  registered read strobe.
- `pmem_write`  out  1  registered write strobe.
- `pmem_wdata`  out  s_line  registered writeback data.
- `pmem_rdata`  in  s_line  line data from adaptor.
- `pmem_resp`  in  1  adaptor transaction complete.
- `i_grants`, `d_grants`, `conflicts`  out  s_cnt  saturating counters: transactions granted to I, granted to D, and IDLE cycles with both requesting.

## Operation
- States: IDLE, BUSY_I, BUSY_D. A `last` register holds the most recent grantee; it resets to I, so D wins the first tie.
- In IDLE, the request is `i_req = i_pmem_read` and `d_req = d_pmem_read | d_pmem_write`.
  - Only one requester asserted: grant it.
  - Both asserted: grant the side not equal to `last`, and increment `conflicts`.
  - No request: stay in IDLE.
- On a grant edge:
  - Latch the winner's address into `pmem_address`.
  - Latch the strobes: D-cache drives both `pmem_read` and `pmem_write`; the I-cache drives `pmem_read=1`, `pmem_write=0`.
  - Latch `d_pmem_wdata` into `pmem_wdata`. For I grants, wdata holds its previous value.
  - Update `last` and increment the winner's grant counter.
  - Enter BUSY_I or BUSY_D.
- If `d_pmem_read` and `d_pmem_write` are both high, the write wins: latch `pmem_write=1`, `pmem_read=0`. The read is served as a new transaction after the write completes.
- In BUSY_x, the memory-side registers hold and requester inputs are ignored.
- When `pmem_resp=1` in BUSY_x:
  - `x_pmem_resp=1` combinationally in the same cycle.
  - At that edge, clear `pmem_read`/`pmem_write` and return to IDLE.
- `i_pmem_rdata` and `d_pmem_rdata` are both wired to `pmem_rdata`. Only the resp strobe is steered.
- The non-granted `*_pmem_resp` is always 0.
- `pmem_resp` in IDLE is ignored and produces no resp to either side.
- Counters saturate at all-ones and do not wrap.

## Timing
- Reset values (all asserted asynchronously while `rst=0`):
  - state=IDLE, last=I.
  - `pmem_read`, `pmem_write`, `pmem_address`, `pmem_wdata` = 0.
  - All counters = 0.
  - `i_pmem_resp`, `d_pmem_resp` = 0.
- Request-to-memory latency is 1 cycle: a request sampled in IDLE at edge N shows `pmem_read`/`pmem_write` high from edge N until the resp edge.
- Response latency is 0: `x_pmem_resp` is high exactly in the cycle(s) in which `pmem_resp` is high while in BUSY_x.
- Back-to-back transactions:
  - After the resp edge, the state is IDLE for at least one cycle, and the memory strobes are low for at least one cycle.
  - The next grant is taken at the following edge.
  - Minimum period per transaction is memory latency + 2 cycles.
- Requesters must hold address, wdata and strobe until resp, and drop the strobe in the cycle after resp. A strobe still high in IDLE is treated as a new request.
- Reset mid-transaction:
  - Strobes drop immediately (asynchronously) and the transaction is abandoned.
  - No resp is generated.
  - The adaptor is reset by the same `rst`.

## Test plan
- Reset: hold `rst=0` mid-BUSY_D with `pmem_write=1`. Required: `pmem_write` drops to 0 immediately, and counters read 0. After release, a D request is granted next edge.
- Single I miss: `i_pmem_read=1`, addr 0x0000_0040, memory resp after 5 cycles, `pmem_rdata`=0xA5…A5. Required:
  - `pmem_read` rises 1 cycle after the request; `pmem_address`=0x40.
  - `i_pmem_resp`=1 for exactly the resp cycle with rdata 0xA5…A5.
  - `d_pmem_resp`=0 throughout.
  - `i_grants`=1.
- Conflict: assert I and D reads in the same cycle after reset. Required:
  - D is served first, then I, then D again if both are re-raised.
  - `conflicts` increments on each contested grant.
- D writeback then fill: `d_pmem_write=1`, addr 0x100, wdata 0x1234…; the cache then issues a read of 0x200. Required:
  - `pmem_wdata` and addr 0x100 are latched for the write.
  - After resp, one IDLE cycle, then `pmem_read` with addr 0x200.
  - `d_grants`=2.
- Input change while busy: during BUSY_I, toggle `d_pmem_address` and assert `d_pmem_read`. Required: `pmem_address` stays constant, and D is granted only after the I resp.
- Counter saturation: preload with `s_cnt`=4 via parameter and run 20 I transactions. Required: `i_grants` = 15 and holds.

Source files
------------

// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module : cache_arbiter
// Brief  : Round-robin sharing of one cacheline memory port by I- and D-cache.
// Rev    : 1.0
// ============================================================================
module cache_arbiter #(
   parameter int S_LINE = 256,
   parameter int S_CNT  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       i_pmem_address,
   input  logic              i_pmem_read,
   output logic [S_LINE-1:0] i_pmem_rdata,
   output logic              i_pmem_resp,
   input  logic [31:0]       d_pmem_address,
   input  logic              d_pmem_read,
   input  logic              d_pmem_write,
   input  logic [S_LINE-1:0] d_pmem_wdata,
   output logic [S_LINE-1:0] d_pmem_rdata,
   output logic              d_pmem_resp,
   output logic [31:0]       pmem_address,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [S_LINE-1:0] pmem_wdata,
   input  logic [S_LINE-1:0] pmem_rdata,
   input  logic              pmem_resp,
   output logic [S_CNT-1:0]  i_grants,
   output logic [S_CNT-1:0]  d_grants,
   output logic [S_CNT-1:0]  conflicts
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY_I = 2'd1,
      ST_BUSY_D = 2'd2
   } state_t;

   localparam logic             SIDE_I  = 1'b0;
   localparam logic             SIDE_D  = 1'b1;
   localparam logic [S_CNT-1:0] CNT_MAX = {S_CNT{1'b1}};
   localparam logic [S_CNT-1:0] CNT_ONE = {{(S_CNT-1){1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic                last_q, last_d;
   logic                pmem_read_q, pmem_read_d;
   logic                pmem_write_q, pmem_write_d;
   logic [31:0]         pmem_address_q, pmem_address_d;
   logic [S_LINE-1:0]   pmem_wdata_q, pmem_wdata_d;
   logic [S_CNT-1:0]    i_grants_q, i_grants_d;
   logic [S_CNT-1:0]    d_grants_q, d_grants_d;
   logic [S_CNT-1:0]    conflicts_q, conflicts_d;

   logic req_icache, req_dcache;
   logic gnt_icache, gnt_dcache;

   function automatic logic [S_CNT-1:0] sat_inc(input logic [S_CNT-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   assign req_icache = i_pmem_read;
   assign req_dcache = d_pmem_read | d_pmem_write;
   // On a tie the side that did not win last time takes the port.
   assign gnt_dcache = req_dcache & (~req_icache | (last_q == SIDE_I));
   assign gnt_icache = req_icache & ~gnt_dcache;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_IDLE;
         last_q         <= SIDE_I;
         pmem_read_q    <= 1'b0;
         pmem_write_q   <= 1'b0;
         pmem_address_q <= '0;
         pmem_wdata_q   <= '0;
         i_grants_q     <= '0;
         d_grants_q     <= '0;
         conflicts_q    <= '0;
      end else begin
         state_q        <= state_d;
         last_q         <= last_d;
         pmem_read_q    <= pmem_read_d;
         pmem_write_q   <= pmem_write_d;
         pmem_address_q <= pmem_address_d;
         pmem_wdata_q   <= pmem_wdata_d;
         i_grants_q     <= i_grants_d;
         d_grants_q     <= d_grants_d;
         conflicts_q    <= conflicts_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      last_d         = last_q;
      pmem_read_d    = pmem_read_q;
      pmem_write_d   = pmem_write_q;
      pmem_address_d = pmem_address_q;
      pmem_wdata_d   = pmem_wdata_q;
      i_grants_d     = i_grants_q;
      d_grants_d     = d_grants_q;
      conflicts_d    = conflicts_q;
      case (state_q)
         ST_IDLE: begin
            if (req_icache && req_dcache) begin
               conflicts_d = sat_inc(conflicts_q);
            end
            if (gnt_dcache) begin
               state_d        = ST_BUSY_D;
               last_d         = SIDE_D;
               pmem_address_d = d_pmem_address;
               // A writeback takes precedence; a pending fill is reissued afterwards.
               pmem_write_d   = d_pmem_write;
               pmem_read_d    = d_pmem_read & ~d_pmem_write;
               pmem_wdata_d   = d_pmem_wdata;
               d_grants_d     = sat_inc(d_grants_q);
            end else if (gnt_icache) begin
               state_d        = ST_BUSY_I;
               last_d         = SIDE_I;
               pmem_address_d = i_pmem_address;
               pmem_read_d    = 1'b1;
               pmem_write_d   = 1'b0;
               i_grants_d     = sat_inc(i_grants_q);
            end
         end
         ST_BUSY_I, ST_BUSY_D: begin
            if (pmem_resp) begin
               state_d      = ST_IDLE;
               pmem_read_d  = 1'b0;
               pmem_write_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign i_pmem_resp  = (state_q == ST_BUSY_I) & pmem_resp;
   assign d_pmem_resp  = (state_q == ST_BUSY_D) & pmem_resp;
   assign i_pmem_rdata = pmem_rdata;
   assign d_pmem_rdata = pmem_rdata;

   assign pmem_address = pmem_address_q;
   assign pmem_read    = pmem_read_q;
   assign pmem_write   = pmem_write_q;
   assign pmem_wdata   = pmem_wdata_q;
   assign i_grants     = i_grants_q;
   assign d_grants     = d_grants_q;
   assign conflicts    = conflicts_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_cache_arbiter
// Brief  : Directed plus randomized transaction bench with a reference model.
// Rev    : 1.0
// ============================================================================
module tb_cache_arbiter;

   localparam int LW   = 256;
   localparam int CW   = 4;
   localparam int CMAX = 15;

   logic            clk;
   logic            rst;
   logic [31:0]     i_pmem_address;
   logic            i_pmem_read;
   logic [LW-1:0]   i_pmem_rdata;
   logic            i_pmem_resp;
   logic [31:0]     d_pmem_address;
   logic            d_pmem_read;
   logic            d_pmem_write;
   logic [LW-1:0]   d_pmem_wdata;
   logic [LW-1:0]   d_pmem_rdata;
   logic            d_pmem_resp;
   logic [31:0]     pmem_address;
   logic            pmem_read;
   logic            pmem_write;
   logic [LW-1:0]   pmem_wdata;
   logic [LW-1:0]   pmem_rdata;
   logic            pmem_resp;
   logic [CW-1:0]   i_grants;
   logic [CW-1:0]   d_grants;
   logic [CW-1:0]   conflicts;

   cache_arbiter #(.S_LINE(LW), .S_CNT(CW)) dut (
      .clk(clk), .rst(rst),
      .i_pmem_address(i_pmem_address), .i_pmem_read(i_pmem_read),
      .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
      .d_pmem_address(d_pmem_address), .d_pmem_read(d_pmem_read),
      .d_pmem_write(d_pmem_write), .d_pmem_wdata(d_pmem_wdata),
      .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
      .pmem_address(pmem_address), .pmem_read(pmem_read),
      .pmem_write(pmem_write), .pmem_wdata(pmem_wdata),
      .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .i_grants(i_grants), .d_grants(d_grants), .conflicts(conflicts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: who won last (0 = I, 1 = D), counters, latched memory-side values.
   bit            last_m;
   int            ig_m, dg_m, cf_m;
   logic [31:0]   exp_addr;
   logic [LW-1:0] exp_wdata;

   function automatic int sat(input int v);
      return (v < CMAX) ? v + 1 : CMAX;
   endfunction

   function automatic logic [LW-1:0] rnd_line();
      logic [LW-1:0] v;
      for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom();
      return v;
   endfunction

   function automatic logic [31:0] rnd_addr();
      return $urandom() & 32'hFFFF_FFE0;
   endfunction

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] req);
      total++;
      assert (obs === req) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      last_m    = 1'b0;
      ig_m      = 0;
      dg_m      = 0;
      cf_m      = 0;
      exp_addr  = '0;
      exp_wdata = '0;
   endtask

   task automatic do_reset();
      rst            = 1'b0;
      i_pmem_read    = 1'b0;
      d_pmem_read    = 1'b0;
      d_pmem_write   = 1'b0;
      pmem_resp      = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b1;
      model_reset();
   endtask

   task automatic chk_counters(input string tag);
      chk({tag, "_igrants"}, i_grants, ig_m);
      chk({tag, "_dgrants"}, d_grants, dg_m);
      chk({tag, "_conflicts"}, conflicts, cf_m);
   endtask

   // One full transaction: grant edge, lat busy cycles, resp cycle, resp edge.
   task automatic step_txn(input int lat, input bit poke, input logic [LW-1:0] rdv);
      bit   win_d;
      bit   rq_i, rq_d;
      logic exp_rd, exp_wr;
      rq_i = i_pmem_read;
      rq_d = d_pmem_read | d_pmem_write;
      if (rq_i && rq_d) begin
         win_d = ~last_m;
         cf_m  = sat(cf_m);
      end else begin
         win_d = rq_d;
      end
      last_m = win_d;
      if (win_d) begin
         exp_addr  = d_pmem_address;
         exp_wr    = d_pmem_write;
         exp_rd    = d_pmem_read & ~d_pmem_write;
         exp_wdata = d_pmem_wdata;
         dg_m      = sat(dg_m);
      end else begin
         exp_addr = i_pmem_address;
         exp_rd   = 1'b1;
         exp_wr   = 1'b0;
         ig_m     = sat(ig_m);
      end
      tick();
      chk("grant_rd", pmem_read, exp_rd);
      chk("grant_wr", pmem_write, exp_wr);
      chk("grant_addr", pmem_address, exp_addr);
      chk("grant_wdata", pmem_wdata, exp_wdata);
      chk_counters("grant");
      for (int k = 0; k < lat; k++) begin
         if (poke) begin
            if (win_d) begin
               i_pmem_address = rnd_addr();
               i_pmem_read    = 1'b1;
            end else begin
               d_pmem_address = rnd_addr();
               if (!d_pmem_write) d_pmem_read = 1'b1;
            end
         end
         tick();
         chk("busy_addr", pmem_address, exp_addr);
         chk("busy_rd", pmem_read, exp_rd);
         chk("busy_wr", pmem_wr_or(exp_wr), exp_wr);
         chk("busy_iresp", i_pmem_resp, 1'b0);
         chk("busy_dresp", d_pmem_resp, 1'b0);
      end
      pmem_rdata = rdv;
      pmem_resp  = 1'b1;
      #1;
      chk("resp_i", i_pmem_resp, !win_d);
      chk("resp_d", d_pmem_resp, win_d);
      chk("rdata_i", i_pmem_rdata, rdv);
      chk("rdata_d", d_pmem_rdata, rdv);
      tick();
      pmem_resp = 1'b0;
      chk("done_rd", pmem_read, 1'b0);
      chk("done_wr", pmem_write, 1'b0);
      if (win_d) begin
         if (d_pmem_write) d_pmem_write = 1'b0;
         else              d_pmem_read  = 1'b0;
      end else begin
         i_pmem_read = 1'b0;
      end
   endtask

   function automatic logic pmem_wr_or(input logic unused_v);
      return pmem_write;
   endfunction

   task automatic idle_step();
      pmem_rdata = rnd_line();
      pmem_resp  = $urandom_range(1, 0) != 0;
      #1;
      chk("idle_iresp", i_pmem_resp, 1'b0);
      chk("idle_dresp", d_pmem_resp, 1'b0);
      tick();
      pmem_resp = 1'b0;
      chk("idle_rd", pmem_read, 1'b0);
      chk("idle_wr", pmem_write, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b0;
      i_pmem_address = '0;
      i_pmem_read    = 1'b0;
      d_pmem_address = '0;
      d_pmem_read    = 1'b0;
      d_pmem_write   = 1'b0;
      d_pmem_wdata   = '0;
      pmem_rdata     = '0;
      pmem_resp      = 1'b0;
      model_reset();
      #2;
      chk("rst_rd", pmem_read, 1'b0);
      chk("rst_wr", pmem_write, 1'b0);
      chk("rst_addr", pmem_address, 32'h0);
      chk("rst_wdata", pmem_wdata, '0);
      chk("rst_iresp", i_pmem_resp, 1'b0);
      chk("rst_dresp", d_pmem_resp, 1'b0);
      chk_counters("rst");
      #21;
      rst = 1'b1;

      // Reset while a writeback is in flight.
      d_pmem_address = 32'h0000_0080;
      d_pmem_wdata   = rnd_line();
      d_pmem_write   = 1'b1;
      tick();
      chk("midrst_pre_wr", pmem_write, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      chk("midrst_wr", pmem_write, 1'b0);
      chk("midrst_rd", pmem_read, 1'b0);
      chk("midrst_dgrants", d_grants, 0);
      chk("midrst_dresp", d_pmem_resp, 1'b0);
      d_pmem_write = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b1;
      model_reset();
      d_pmem_address = 32'h0000_0180;
      d_pmem_read    = 1'b1;
      step_txn(2, 1'b0, rnd_line());

      // Single I miss.
      do_reset();
      i_pmem_address = 32'h0000_0040;
      i_pmem_read    = 1'b1;
      step_txn(5, 1'b0, {32{8'hA5}});
      chk("imiss_igrants", i_grants, 1);

      // Contested requests alternate starting with D.
      do_reset();
      i_pmem_address = 32'h0000_1000;
      d_pmem_address = 32'h0000_2000;
      i_pmem_read    = 1'b1;
      d_pmem_read    = 1'b1;
      step_txn(1, 1'b0, rnd_line());
      d_pmem_read = 1'b1;
      step_txn(2, 1'b0, rnd_line());
      i_pmem_read = 1'b1;
      step_txn(0, 1'b0, rnd_line());
      step_txn(1, 1'b0, rnd_line());
      chk("conflict_count", conflicts, 3);

      // Writeback with a fill queued behind it.
      do_reset();
      d_pmem_address = 32'h0000_0100;
      d_pmem_wdata   = {8{32'h1234_5678}};
      d_pmem_write   = 1'b1;
      d_pmem_read    = 1'b1;
      step_txn(2, 1'b0, rnd_line());
      d_pmem_address = 32'h0000_0200;
      step_txn(2, 1'b0, rnd_line());
      chk("wb_dgrants", d_grants, 2);

      // Other side changes while the port is busy.
      do_reset();
      i_pmem_address = 32'h0000_03C0;
      i_pmem_read    = 1'b1;
      step_txn(4, 1'b1, rnd_line());
      step_txn(1, 1'b0, rnd_line());

      // Grant counter saturation.
      do_reset();
      for (int n = 0; n < 20; n++) begin
         i_pmem_address = rnd_addr();
         i_pmem_read    = 1'b1;
         step_txn($urandom_range(2, 0), 1'b0, rnd_line());
      end
      chk("sat_igrants", i_grants, CMAX);

      // Randomized traffic.
      do_reset();
      for (int n = 0; n < 80; n++) begin
         if (!i_pmem_read && $urandom_range(1, 0) != 0) begin
            i_pmem_address = rnd_addr();
            i_pmem_read    = 1'b1;
         end
         if (!d_pmem_read && !d_pmem_write) begin
            case ($urandom_range(3, 0))
               1: begin
                  d_pmem_address = rnd_addr();
                  d_pmem_read    = 1'b1;
               end
               2: begin
                  d_pmem_address = rnd_addr();
                  d_pmem_wdata   = rnd_line();
                  d_pmem_write   = 1'b1;
               end
               3: begin
                  d_pmem_address = rnd_addr();
                  d_pmem_wdata   = rnd_line();
                  d_pmem_write   = 1'b1;
                  d_pmem_read    = 1'b1;
               end
               default: ;
            endcase
         end
         if (!i_pmem_read && !d_pmem_read && !d_pmem_write) idle_step();
         else step_txn($urandom_range(4, 0), $urandom_range(1, 0) != 0, rnd_line());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
